// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-bank dump reader.
// The dump walks addresses modulo NUM_REGS, so next_addr wraps explicitly.
package regfile_pkg;

   localparam int ADDR_W   = 5;
   localparam int DATA_W   = 32;
   localparam int NUM_REGS = 32;

   typedef enum logic [1:0] {IDLE, READ, SEND, DONE} dump_state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } dump_word_t;

   // Wrap is explicit so NUM_REGS need not be a power of two.
   function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
      return (a == ADDR_W'(NUM_REGS - 1)) ? '0 : a + 1'b1;
   endfunction

endpackage

// File: rtl/regfile_dump_reader.sv
// Walks an inclusive register range on a spare read port and streams the
// (address, data) pairs out over valid/ready, one word per READ/SEND pair.
module regfile_dump_reader
   import regfile_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   input  logic [ADDR_W-1:0] first_addr_i,
   input  logic [ADDR_W-1:0] last_addr_i,
   input  logic              abort_i,
   output logic [ADDR_W-1:0] rf_addr_o,
   input  logic [DATA_W-1:0] rf_rdata_i,
   output logic              m_valid_o,
   input  logic              m_ready_i,
   output logic [ADDR_W-1:0] m_addr_o,
   output logic [DATA_W-1:0] m_data_o,
   output logic              busy_o,
   output logic              done_o
);

   dump_state_t       state_q, state_d;
   logic [ADDR_W-1:0] cur_q, cur_d;
   logic [ADDR_W-1:0] last_q, last_d;
   dump_word_t        word_q, word_d;
   logic              valid_q, valid_d;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cur_q   <= '0;
         last_q  <= '0;
         word_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
         last_q  <= last_d;
         word_q  <= word_d;
         valid_q <= valid_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cur_d     = cur_q;
      last_d    = last_q;
      word_d    = word_q;
      valid_d   = valid_q;
      rf_addr_o = '0;
      case (state_q)
         IDLE: begin
            // abort beats a simultaneous start
            if (start_i && !abort_i) begin
               cur_d   = first_addr_i;
               last_d  = last_addr_i;
               state_d = READ;
            end
         end
         READ: begin
            rf_addr_o = cur_q;
            if (abort_i) begin
               state_d = IDLE;
            end else begin
               word_d.addr = cur_q;
               word_d.data = rf_rdata_i;
               valid_d     = 1'b1;
               state_d     = SEND;
            end
         end
         SEND: begin
            if (abort_i) begin
               valid_d = 1'b0;
               state_d = IDLE;
            end else if (m_ready_i) begin
               valid_d = 1'b0;
               if (cur_q == last_q) begin
                  state_d = DONE;
               end else begin
                  cur_d   = next_addr(cur_q);
                  state_d = READ;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign m_valid_o = valid_q;
   assign m_addr_o  = word_q.addr;
   assign m_data_o  = word_q.data;
   assign busy_o    = (state_q != IDLE);
   assign done_o    = (state_q == DONE);

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench: dump reader attached to a register-bank model with
// rN = 0x1000_0000+N and r0 hardwired to zero.
module tb_regfile_dump_reader;
   import regfile_pkg::*;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start, abort, m_ready;
   logic [ADDR_W-1:0] first_addr, last_addr;
   logic [ADDR_W-1:0] rf_addr, m_addr;
   logic [DATA_W-1:0] rf_rdata, m_data;
   logic              m_valid, busy, done;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int start_cyc;
   int got, done_cyc;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [DATA_W-1:0] bank(input logic [ADDR_W-1:0] a);
      return (a == '0) ? '0 : 32'h1000_0000 + DATA_W'(a);
   endfunction

   assign rf_rdata = bank(rf_addr);

   regfile_dump_reader dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .first_addr_i(first_addr),
      .last_addr_i(last_addr), .abort_i(abort), .rf_addr_o(rf_addr),
      .rf_rdata_i(rf_rdata), .m_valid_o(m_valid), .m_ready_i(m_ready),
      .m_addr_o(m_addr), .m_data_o(m_data), .busy_o(busy), .done_o(done)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // advance one clock; inputs are driven and outputs sampled at negedge
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic kick(input logic [ADDR_W-1:0] f, input logic [ADDR_W-1:0] l);
      first_addr = f;
      last_addr  = l;
      start      = 1'b1;
      start_cyc  = cyc;
      step();
      start      = 1'b0;
   endtask

   // Consume words until done, checking order, data and READ-phase rf_addr.
   task automatic collect(input logic [ADDR_W-1:0] a0, input int maxc,
                          output int n, output int dcyc);
      logic [ADDR_W-1:0] a;
      a    = a0;
      n    = 0;
      dcyc = -1;
      for (int c = 0; c < maxc && dcyc < 0; c++) begin
         if (m_valid && m_ready) begin
            chk("word_addr", 64'(m_addr), 64'(a));
            chk("word_data", 64'(m_data), 64'(bank(a)));
            a = next_addr(a);
            n++;
         end else if (busy && !m_valid && !done) begin
            chk("rf_addr_read", 64'(rf_addr), 64'(a));
         end
         if (done) dcyc = cyc - start_cyc;
         step();
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_valid"}, 64'(m_valid), 64'd0);
      chk({tag, "_busy"},  64'(busy),    64'd0);
      chk({tag, "_done"},  64'(done),    64'd0);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; m_ready = 1'b1;
      first_addr = '0; last_addr = '0;
      @(negedge clk);
      step();
      // reset state
      chk_idle("rst");
      chk("rst_rf_addr", 64'(rf_addr), 64'd0);
      chk("rst_m_addr",  64'(m_addr),  64'd0);
      chk("rst_m_data",  64'(m_data),  64'd0);
      rst_n = 1'b1;
      step();

      // start with abort in the same cycle is refused
      abort = 1'b1;
      kick(5'd3, 5'd4);
      abort = 1'b0;
      chk_idle("start_abort");

      // full dump: 32 words, done 65 cycles after start
      kick(5'd0, 5'd31);
      collect(5'd0, 200, got, done_cyc);
      chk("full_count", 64'(got), 64'd32);
      chk("full_done_cyc", 64'(done_cyc), 64'd65);
      chk_idle("full_after");

      // wrap range 30,31,0,1
      kick(5'd30, 5'd1);
      collect(5'd30, 100, got, done_cyc);
      chk("wrap_count", 64'(got), 64'd4);
      chk("wrap_done_cyc", 64'(done_cyc), 64'd9);
      chk_idle("wrap_after");

      // backpressure: word held stable for 5 cycles of m_ready low
      m_ready = 1'b0;
      kick(5'd3, 5'd5);
      step();
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", 64'(m_valid), 64'd1);
         chk("bp_addr",  64'(m_addr),  64'd3);
         chk("bp_data",  64'(m_data),  64'h1000_0003);
         step();
      end
      m_ready = 1'b1;
      collect(5'd3, 100, got, done_cyc);
      chk("bp_count", 64'(got), 64'd3);
      chk("bp_done_cyc", 64'(done_cyc), 64'd12);

      // single register
      step();
      kick(5'd7, 5'd7);
      collect(5'd7, 50, got, done_cyc);
      chk("single_count", 64'(got), 64'd1);
      chk("single_done_cyc", 64'(done_cyc), 64'd3);
      chk_idle("single_after");

      // abort while the fourth word is pending in SEND
      kick(5'd10, 5'd20);
      for (int i = 0; i < 7; i++) begin
         chk("ab_no_done", 64'(done), 64'd0);
         step();
      end
      chk("ab_pending_valid", 64'(m_valid), 64'd1);
      chk("ab_pending_addr",  64'(m_addr),  64'd13);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk_idle("ab_next");
      step();
      chk("ab_still_no_done", 64'(done), 64'd0);
      kick(5'd2, 5'd2);
      collect(5'd2, 50, got, done_cyc);
      chk("ab_restart_count", 64'(got), 64'd1);
      chk("ab_restart_done_cyc", 64'(done_cyc), 64'd3);

      // start while busy and changed first/last are ignored
      kick(5'd4, 5'd8);
      first_addr = 5'd20;
      last_addr  = 5'd25;
      start      = 1'b1;
      step();
      start      = 1'b0;
      collect(5'd4, 100, got, done_cyc);
      chk("busy_start_count", 64'(got), 64'd5);
      chk("busy_start_done_cyc", 64'(done_cyc), 64'd11);

      // synchronous reset in the middle of a dump
      kick(5'd0, 5'd31);
      for (int i = 0; i < 6; i++) step();
      chk("mid_busy", 64'(busy), 64'd1);
      rst_n = 1'b0;
      step();
      chk_idle("midrst");
      chk("midrst_rf_addr", 64'(rf_addr), 64'd0);
      chk("midrst_m_addr",  64'(m_addr),  64'd0);
      chk("midrst_m_data",  64'(m_data),  64'd0);
      rst_n = 1'b1;
      step();
      chk_idle("midrst_after");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
